// File: rtl/minibus_timer_pkg.sv
// -----------------------------------------------------------------------------
// minibus_timer_pkg
// Shared definitions for the minibus machine timer: register byte offsets
// inside the timer window, the handshake FSM state type and the 64-bit word
// type used for mtime / mtimecmp.
// -----------------------------------------------------------------------------
package minibus_timer_pkg;

    // Register byte offsets (word aligned). 0x0C is intentionally unmapped.
    localparam logic [7:0] TMR_MSIP        = 8'h00;
    localparam logic [7:0] TMR_CTRL        = 8'h04;
    localparam logic [7:0] TMR_PRESCALE    = 8'h08;
    localparam logic [7:0] TMR_MTIME_LO    = 8'h10;
    localparam logic [7:0] TMR_MTIME_HI    = 8'h14;
    localparam logic [7:0] TMR_MTIMECMP_LO = 8'h18;
    localparam logic [7:0] TMR_MTIMECMP_HI = 8'h1C;

    typedef logic [63:0] word64_t;

    // Compare value out of reset: the largest value, so no interrupt fires
    // until software programs a real deadline.
    localparam word64_t MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } tmr_state_t;

endpackage

// File: rtl/minibus_timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Enable-gated 16-bit prescale counter. While enabled the counter advances
// every cycle; when it equals the programmed prescale value it wraps to 0 and
// the tick strobe is high for that cycle, so the tick period is prescale+1.
// Ports:
//   clk, nrst  : clock, asynchronous active-low reset
//   enable     : counting enable (CTRL.enable)
//   clear      : restart the count (PRESCALE register written)
//   prescale   : terminal count
//   tick       : one-cycle strobe, mtime advances on the edge it is high
// -----------------------------------------------------------------------------
module timer_prescaler (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] count_r;
    logic        hit_s;

    // Terminal-count detect; decoded from the count register so the tick
    // lines up with the edge on which the count wraps.
    always_comb begin
        if (enable && (count_r == prescale)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Prescale counter: restarts on a PRESCALE write or while disabled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_r <= 16'd0;
        end else if (clear || !enable) begin
            count_r <= 16'd0;
        end else if (hit_s) begin
            count_r <= 16'd0;
        end else begin
            count_r <= count_r + 16'd1;
        end
    end

    assign tick = hit_s;

endmodule

// File: rtl/minibus_timer.sv
// -----------------------------------------------------------------------------
// minibus_timer
// CLINT-style machine timer on the minibus. Holds a free-running 64-bit mtime,
// a 64-bit mtimecmp, a prescaler and a software-interrupt bit, and drives
// registered timer / software interrupt levels.
// Ports:
//   clk, nrst            : clock, asynchronous active-low reset
//   req_addr             : byte offset inside the timer window
//   req_wdata            : write data
//   req_ren, req_wen     : read / write request (held until res_ready)
//   res_rdata, res_err   : response data / error, valid while res_ready=1
//   res_ready            : one-cycle response strobe, 1 cycle after request
//   timer_irq, soft_irq  : level interrupts
// -----------------------------------------------------------------------------
module minibus_timer
    import minibus_timer_pkg::*;
#(
    parameter int unsigned ADDR_W       = 5,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              req_ren,
    input  logic              req_wen,
    output logic [31:0]       res_rdata,
    output logic              res_ready,
    output logic              res_err,
    output logic              timer_irq,
    output logic              soft_irq
);

    tmr_state_t  state_r;
    logic [31:0] res_rdata_r;
    logic        res_ready_r;
    logic        res_err_r;
    logic        timer_irq_r;
    logic        soft_irq_r;

    logic        msip_r;
    logic        ctrl_en_r;
    logic [15:0] prescale_r;
    word64_t     mtime_r;
    word64_t     mtimecmp_r;
    logic [31:0] shadow_r;

    logic [7:0]  off_s;
    logic        hi_ok_s;
    logic        mapped_s;
    logic [31:0] rdata_s;
    logic        err_s;
    logic        go_s;
    logic        rd_ok_s;
    logic        wr_ok_s;
    logic        wr_prescale_s;
    logic        tick_s;

    // Address decode, read mux and error classification of the current request.
    always_comb begin
        off_s    = 8'(req_addr);
        // Offset bits above the 8-bit map (if ADDR_W is ever widened) must be 0.
        hi_ok_s  = ((req_addr >> 4'd8) == {ADDR_W{1'b0}});
        mapped_s = 1'b1;
        rdata_s  = 32'h0000_0000;
        case (off_s)
            TMR_MSIP:        rdata_s = {31'h0000_0000, msip_r};
            TMR_CTRL:        rdata_s = {31'h0000_0000, ctrl_en_r};
            TMR_PRESCALE:    rdata_s = {16'h0000, prescale_r};
            TMR_MTIME_LO:    rdata_s = mtime_r[31:0];
            TMR_MTIME_HI:    rdata_s = shadow_r;
            TMR_MTIMECMP_LO: rdata_s = mtimecmp_r[31:0];
            TMR_MTIMECMP_HI: rdata_s = mtimecmp_r[63:32];
            default: begin
                mapped_s = 1'b0;
                rdata_s  = 32'h0000_0000;
            end
        endcase
        err_s   = !mapped_s || !hi_ok_s || (req_addr[1:0] != 2'b00) ||
                  (req_ren && req_wen);
        // Requests are only sampled in IDLE; RESP ignores the inputs.
        go_s    = (state_r == IDLE) && (req_ren || req_wen);
        rd_ok_s = go_s && req_ren && !err_s;
        wr_ok_s = go_s && req_wen && !err_s;
        wr_prescale_s = wr_ok_s && (off_s == TMR_PRESCALE);
    end

    timer_prescaler u_prescaler (
        .clk      (clk),
        .nrst     (nrst),
        .enable   (ctrl_en_r),
        .clear    (wr_prescale_s),
        .prescale (prescale_r),
        .tick     (tick_s)
    );

    // Handshake FSM with registered response: one response cycle per request.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= IDLE;
            res_ready_r <= 1'b0;
            res_err_r   <= 1'b0;
            res_rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        state_r     <= RESP;
                        res_ready_r <= 1'b1;
                        res_err_r   <= err_s;
                        res_rdata_r <= rd_ok_s ? rdata_s : 32'h0000_0000;
                    end else begin
                        state_r     <= IDLE;
                        res_ready_r <= 1'b0;
                        res_err_r   <= 1'b0;
                        res_rdata_r <= 32'h0000_0000;
                    end
                end
                RESP: begin
                    state_r     <= IDLE;
                    res_ready_r <= 1'b0;
                    res_err_r   <= 1'b0;
                    res_rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r     <= IDLE;
                    res_ready_r <= 1'b0;
                    res_err_r   <= 1'b0;
                    res_rdata_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Control registers and compare value, written on the accepting edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            msip_r     <= 1'b0;
            ctrl_en_r  <= 1'b0;
            prescale_r <= PRESCALE_RST;
            mtimecmp_r <= MTIMECMP_RST;
        end else if (wr_ok_s) begin
            case (off_s)
                TMR_MSIP:        msip_r             <= req_wdata[0];
                TMR_CTRL:        ctrl_en_r          <= req_wdata[0];
                TMR_PRESCALE:    prescale_r         <= req_wdata[15:0];
                TMR_MTIMECMP_LO: mtimecmp_r[31:0]   <= req_wdata;
                TMR_MTIMECMP_HI: mtimecmp_r[63:32]  <= req_wdata;
                default:         msip_r             <= msip_r;
            endcase
        end else begin
            msip_r <= msip_r;
        end
    end

    // mtime and its high-half shadow. A software write to either half wins
    // over a tick on the same edge; reading LO snapshots HI so a following
    // HI read is coherent with the LO value even across a carry.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mtime_r  <= 64'h0000_0000_0000_0000;
            shadow_r <= 32'h0000_0000;
        end else begin
            if (rd_ok_s && (off_s == TMR_MTIME_LO)) begin
                shadow_r <= mtime_r[63:32];
            end else begin
                shadow_r <= shadow_r;
            end
            if (wr_ok_s && (off_s == TMR_MTIME_LO)) begin
                mtime_r[31:0] <= req_wdata;
            end else if (wr_ok_s && (off_s == TMR_MTIME_HI)) begin
                mtime_r[63:32] <= req_wdata;
            end else if (tick_s) begin
                mtime_r <= mtime_r + 64'd1;
            end else begin
                mtime_r <= mtime_r;
            end
        end
    end

    // Interrupt levels, registered from the current register values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            timer_irq_r <= 1'b0;
            soft_irq_r  <= 1'b0;
        end else begin
            timer_irq_r <= ctrl_en_r && (mtime_r >= mtimecmp_r);
            soft_irq_r  <= msip_r;
        end
    end

    assign res_rdata = res_rdata_r;
    assign res_ready = res_ready_r;
    assign res_err   = res_err_r;
    assign timer_irq = timer_irq_r;
    assign soft_irq  = soft_irq_r;

endmodule

// File: tb/tb_minibus_timer.sv
// -----------------------------------------------------------------------------
// tb_minibus_timer
// Directed bench for minibus_timer with a behavioural model of the register
// map, prescaler period and handshake, compared against the DUT every cycle,
// plus hand-computed literal expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_minibus_timer;

    logic        clk;
    logic        nrst;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ren;
    logic        req_wen;
    logic [31:0] res_rdata;
    logic        res_ready;
    logic        res_err;
    logic        timer_irq;
    logic        soft_irq;

    int n_vec = 0;
    int n_err = 0;

    minibus_timer #(.ADDR_W(5), .PRESCALE_RST(16'd0)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .res_rdata (res_rdata),
        .res_ready (res_ready),
        .res_err   (res_err),
        .timer_irq (timer_irq),
        .soft_irq  (soft_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime, m_cmp;
    logic [15:0] m_pre, m_phase;
    logic [31:0] m_shadow;
    logic        m_msip, m_en, m_busy;
    logic        exp_ready, exp_err, exp_tirq, exp_sirq;
    logic [31:0] exp_rdata;

    task automatic model_reset();
        m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_pre = 16'd0; m_phase = 16'd0; m_shadow = 32'd0;
        m_msip = 1'b0; m_en = 1'b0; m_busy = 1'b0;
        exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
        exp_tirq = 1'b0; exp_sirq = 1'b0;
    endtask

    // One clock edge: interrupts from old state, one request per two cycles,
    // tick every (PRESCALE+1) enabled cycles, software write beats tick.
    task automatic model_step();
        logic        tick, old_en, restart, mapped, err;
        logic [31:0] rd;
        logic [63:0] new_mtime;
        tick      = m_en && (m_phase == m_pre);
        old_en    = m_en;
        exp_tirq  = m_en && (m_mtime >= m_cmp);
        exp_sirq  = m_msip;
        restart   = 1'b0;
        new_mtime = tick ? m_mtime + 64'd1 : m_mtime;
        if (!m_busy && (req_ren || req_wen)) begin
            m_busy = 1'b1;
            mapped = 1'b1;
            rd     = 32'd0;
            case (req_addr)
                5'h00: rd = {31'd0, m_msip};
                5'h04: rd = {31'd0, m_en};
                5'h08: rd = {16'd0, m_pre};
                5'h10: rd = m_mtime[31:0];
                5'h14: rd = m_shadow;
                5'h18: rd = m_cmp[31:0];
                5'h1C: rd = m_cmp[63:32];
                default: mapped = 1'b0;
            endcase
            err       = !mapped || (req_ren && req_wen);
            exp_ready = 1'b1;
            exp_err   = err;
            exp_rdata = (!err && req_ren) ? rd : 32'd0;
            if (!err && req_ren && req_addr == 5'h10) m_shadow = m_mtime[63:32];
            if (!err && req_wen) begin
                case (req_addr)
                    5'h00: m_msip = req_wdata[0];
                    5'h04: m_en   = req_wdata[0];
                    5'h08: begin m_pre = req_wdata[15:0]; restart = 1'b1; end
                    5'h10: new_mtime = {m_mtime[63:32], req_wdata};
                    5'h14: new_mtime = {req_wdata, m_mtime[31:0]};
                    5'h18: m_cmp[31:0]  = req_wdata;
                    5'h1C: m_cmp[63:32] = req_wdata;
                    default: ;
                endcase
            end
        end else begin
            m_busy = 1'b0; exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
        end
        if (restart || !old_en || tick) m_phase = 16'd0;
        else                            m_phase = m_phase + 16'd1;
        m_mtime = new_mtime;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) model_reset();
            else       model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("res_ready", res_ready, exp_ready);
        check("timer_irq", timer_irq, exp_tirq);
        check("soft_irq",  soft_irq,  exp_sirq);
        if (exp_ready) begin
            check("res_rdata", res_rdata, exp_rdata);
            check("res_err",   res_err,   exp_err);
        end
    end

    // ---------------- bus access ----------------
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic bus(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] d);
        int   waited = 0;
        logic seen   = 1'b0;
        req_addr = a; req_wdata = d; req_ren = rd; req_wen = wr;
        while (!seen && waited < 4) begin
            @(negedge clk);
            waited++;
            if (res_ready) seen = 1'b1;
        end
        check("latency", waited, 1);
        last_rdata = res_rdata;
        last_err   = res_err;
        req_ren = 1'b0; req_wen = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d);
        check("wr_err", last_err, 1'b0);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] q);
        bus(1'b1, 1'b0, a, 32'd0);
        q = last_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [4:0]  rst_addr [7] = '{5'h00, 5'h04, 5'h08, 5'h10, 5'h14, 5'h18, 5'h1C};
    logic [31:0] rst_val  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] q, lo, hi;
    logic        seen;

    initial begin
        nrst = 1'b0; req_addr = 5'd0; req_wdata = 32'd0; req_ren = 1'b0; req_wen = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Reset values
        check("rst_timer_irq", timer_irq, 1'b0);
        for (int i = 0; i < 7; i++) begin
            rd(rst_addr[i], q);
            check("rst_read", q, rst_val[i]);
        end

        // Software interrupt
        wr(5'h00, 32'd1);
        check("soft_irq_set", soft_irq, 1'b1);
        wr(5'h00, 32'd0);
        check("soft_irq_clr", soft_irq, 1'b0);

        // Prescaled counting: tick every 4 cycles for ~40 cycles
        wr(5'h08, 32'd3);
        wr(5'h04, 32'd1);
        repeat (40) @(negedge clk);
        rd(5'h10, q);
        check("prescale_count", (q >= 32'd9 && q <= 32'd11), 1'b1);

        // Timer interrupt at mtime == 20
        wr(5'h04, 32'd0);
        wr(5'h08, 32'd0);
        wr(5'h10, 32'd0);
        wr(5'h14, 32'd0);
        wr(5'h1C, 32'd0);
        wr(5'h18, 32'd20);
        wr(5'h04, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (timer_irq) seen = 1'b1;
        end
        check("irq_rise_seen", seen, 1'b1);
        rd(5'h10, q);
        check("irq_mtime_ge_20", q >= 32'd20, 1'b1);
        wr(5'h18, 32'hFFFFFFFF);
        wr(5'h1C, 32'hFFFFFFFF);
        check("irq_fall", timer_irq, 1'b0);

        // Atomic read across the low-word carry
        wr(5'h04, 32'd0);
        wr(5'h14, 32'd0);
        wr(5'h10, 32'hFFFFFFFE);
        wr(5'h04, 32'd1);
        rd(5'h10, lo);
        rd(5'h14, hi);
        check("atomic_lo", lo, 32'hFFFFFFFF);
        check("atomic_hi", hi, 32'd0);
        rd(5'h10, lo);
        rd(5'h14, hi);
        check("atomic_hi_after_carry", hi, 32'd1);

        // Error cases: unmapped, misaligned, read+write together
        rd(5'h0C, q);
        check("err_unmapped", {last_err, q}, {1'b1, 32'd0});
        rd(5'h02, q);
        check("err_misaligned", {last_err, q}, {1'b1, 32'd0});
        bus(1'b1, 1'b1, 5'h04, 32'd0);
        check("err_rw_both", {last_err, last_rdata}, {1'b1, 32'd0});
        rd(5'h04, q);
        check("ctrl_unchanged", q, 32'd1);

        // Write wins over a simultaneous tick (PRESCALE=1, write on tick edge)
        wr(5'h08, 32'd1);
        wr(5'h10, 32'd5);
        rd(5'h10, q);
        check("write_beats_tick", q, 32'd5);

        // Asynchronous reset during the response cycle
        req_addr = 5'h04; req_ren = 1'b1;
        @(posedge clk);
        #1;
        check("resp_before_reset", res_ready, 1'b1);
        nrst = 1'b0;
        #1;
        check("ready_drops_on_reset", res_ready, 1'b0);
        req_ren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        rd(5'h1C, q);
        check("post_reset_cmp_hi", q, 32'hFFFFFFFF);
        rd(5'h04, q);
        check("post_reset_ctrl", q, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
